// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: one-hot column drive, synchronized row sampling,
// press/release debounce over scan ticks, single held key code output.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// SCAN     | rotate column drive each tick until a single row is seen
// DEBOUNCE | column held; confirm the same row over consecutive ticks
// PRESSED  | key_valid high, code frozen; wait for consecutive zero ticks
module keypad_scanner #(
  parameter int SCAN_DIV       = 100000,
  parameter int DEBOUNCE_TICKS = 4
) (
  input  logic       clk,
  input  logic       reset_p,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_value,
  output logic       key_valid,
  output logic       key_pulse
);

  localparam int TW = $clog2(SCAN_DIV);
  localparam int DW = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_TICKS - 1);

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2
  } state_t;

  state_t        state, state_nx;
  logic [3:0]    row_m, row_s;
  logic [TW-1:0] tick_cnt;
  logic          tick;
  logic [1:0]    col_idx, col_idx_nx;
  logic [3:0]    lat_row, lat_row_nx;
  logic [1:0]    lat_idx, lat_idx_nx;
  logic [DW-1:0] db_cnt, db_cnt_nx;
  logic [3:0]    key_value_nx;
  logic          key_valid_nx, key_pulse_nx;
  logic          row_valid;
  logic [1:0]    row_idx;

  assign tick = (tick_cnt == TICK_LAST);
  // column drive is decoded from the index so it can never be zero or multi-hot
  assign col  = 4'b0001 << col_idx;

  assign row_valid = (row_s != 4'b0000) && ((row_s & (row_s - 4'b0001)) == 4'b0000);

  always_comb begin
    row_idx = 2'd0;
    case (row_s)
      4'b0010: row_idx = 2'd1;
      4'b0100: row_idx = 2'd2;
      4'b1000: row_idx = 2'd3;
      default: row_idx = 2'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_p) begin
      row_m     <= 4'b0000;
      row_s     <= 4'b0000;
      tick_cnt  <= '0;
      state     <= SCAN;
      col_idx   <= 2'd0;
      lat_row   <= 4'b0000;
      lat_idx   <= 2'd0;
      db_cnt    <= '0;
      key_value <= 4'h0;
      key_valid <= 1'b0;
      key_pulse <= 1'b0;
    end else begin
      row_m     <= row;
      row_s     <= row_m;
      tick_cnt  <= tick ? '0 : tick_cnt + TW'(1);
      state     <= state_nx;
      col_idx   <= col_idx_nx;
      lat_row   <= lat_row_nx;
      lat_idx   <= lat_idx_nx;
      db_cnt    <= db_cnt_nx;
      key_value <= key_value_nx;
      key_valid <= key_valid_nx;
      key_pulse <= key_pulse_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    col_idx_nx   = col_idx;
    lat_row_nx   = lat_row;
    lat_idx_nx   = lat_idx;
    db_cnt_nx    = db_cnt;
    key_value_nx = key_value;
    key_valid_nx = key_valid;
    key_pulse_nx = 1'b0;
    case (state)
      SCAN: begin
        if (tick) begin
          if (row_valid) begin
            lat_row_nx = row_s;
            lat_idx_nx = row_idx;
            db_cnt_nx  = DW'(1);
            state_nx   = DEBOUNCE;
          end else begin
            col_idx_nx = col_idx + 2'd1;
          end
        end
      end
      DEBOUNCE: begin
        if (tick) begin
          if (row_s == lat_row) begin
            if (db_cnt == DB_LAST) begin
              state_nx     = PRESSED;
              key_valid_nx = 1'b1;
              key_pulse_nx = 1'b1;
              key_value_nx = {lat_idx, col_idx};
              db_cnt_nx    = '0;
            end else begin
              db_cnt_nx = db_cnt + DW'(1);
            end
          end else begin
            state_nx   = SCAN;
            col_idx_nx = col_idx + 2'd1;
          end
        end
      end
      PRESSED: begin
        // db_cnt is reused here as the consecutive-release counter
        if (tick) begin
          if (row_s == 4'b0000) begin
            if (db_cnt == DB_LAST) begin
              state_nx     = SCAN;
              key_valid_nx = 1'b0;
              col_idx_nx   = col_idx + 2'd1;
              db_cnt_nx    = '0;
            end else begin
              db_cnt_nx = db_cnt + DW'(1);
            end
          end else begin
            db_cnt_nx = '0;
          end
        end
      end
      default: state_nx = SCAN;
    endcase
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_TICKS=3 and a
// simple keypad model that returns rows only while the matching column is driven.
module tb_keypad_scanner;

  logic       clk;
  logic       reset_p;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key_value;
  logic       key_valid;
  logic       key_pulse;

  logic       key_on;
  logic [3:0] k_rows;
  logic [3:0] k_col;

  int n_cmp = 0;
  int n_err = 0;

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_TICKS(3)) dut (
    .clk       (clk),
    .reset_p   (reset_p),
    .row       (row),
    .col       (col),
    .key_value (key_value),
    .key_valid (key_valid),
    .key_pulse (key_pulse)
  );

  assign row = (key_on && (col == k_col)) ? k_rows : 4'b0000;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // steps n cycles while a key is accepted, checking it stays held without a new strobe
  task automatic hold_check(input int n, input logic [3:0] code, input string tag);
    repeat (n) begin
      step(1);
      check({tag, "_valid"}, {3'b000, key_valid}, 4'h1);
      check({tag, "_pulse"}, {3'b000, key_pulse}, 4'h0);
      check({tag, "_value"}, key_value, code);
    end
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] exp_cols [5];
    exp_cols[0] = 4'b0001;
    exp_cols[1] = 4'b0010;
    exp_cols[2] = 4'b0100;
    exp_cols[3] = 4'b1000;
    exp_cols[4] = 4'b0001;

    reset_p = 1'b1;
    key_on  = 1'b0;
    k_rows  = 4'b0000;
    k_col   = 4'b0001;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_col",   col,                   4'b0001);
    check("rst_valid", {3'b000, key_valid},   4'h0);
    check("rst_pulse", {3'b000, key_pulse},   4'h0);
    check("rst_value", key_value,             4'h0);
    reset_p = 1'b0;

    // idle scanning, 4 clocks per column
    step(3);
    check("idle_dwell", col, 4'b0001);
    step(1);
    check("idle_c1", col, 4'b0010);
    check("idle_c1_valid", {3'b000, key_valid}, 4'h0);
    step(4);
    check("idle_c2", col, 4'b0100);
    step(4);
    check("idle_c3", col, 4'b1000);
    step(4);
    check("idle_wrap", col, 4'b0001);
    check("idle_pulse", {3'b000, key_pulse}, 4'h0);
    check("idle_value", key_value, 4'h0);

    // hold r=2,c=1: detect at next 0010 tick, valid two ticks later
    k_rows = 4'b0100; k_col = 4'b0010; key_on = 1'b1;
    step(8);
    check("k9_detect_col",   col,                 4'b0010);
    check("k9_detect_valid", {3'b000, key_valid}, 4'h0);
    step(7);
    check("k9_pre_valid", {3'b000, key_valid}, 4'h0);
    step(1);
    check("k9_valid", {3'b000, key_valid}, 4'h1);
    check("k9_pulse", {3'b000, key_pulse}, 4'h1);
    check("k9_value", key_value,           4'h9);
    check("k9_col",   col,                 4'b0010);
    step(1);
    check("k9_pulse_end", {3'b000, key_pulse}, 4'h0);
    check("k9_valid_hold", {3'b000, key_valid}, 4'h1);
    step(7);
    check("k9_col_hold",   col,                 4'b0010);
    check("k9_value_hold", key_value,           4'h9);

    // reset while PRESSED
    reset_p = 1'b1; key_on = 1'b0;
    step(1);
    check("mid_rst_col",   col,                 4'b0001);
    check("mid_rst_valid", {3'b000, key_valid}, 4'h0);
    check("mid_rst_value", key_value,           4'h0);
    check("mid_rst_pulse", {3'b000, key_pulse}, 4'h0);
    reset_p = 1'b0;

    // bounce r=3,c=3 for one tick
    step(12);
    check("bnc_reach_c3", col, 4'b1000);
    k_rows = 4'b1000; k_col = 4'b1000; key_on = 1'b1;
    step(4);
    check("bnc_col_held", col,                 4'b1000);
    check("bnc_valid0",   {3'b000, key_valid}, 4'h0);
    key_on = 1'b0;
    step(4);
    check("bnc_resume",  col,                 4'b0001);
    check("bnc_valid1",  {3'b000, key_valid}, 4'h0);
    check("bnc_pulse",   {3'b000, key_pulse}, 4'h0);
    step(4);
    check("bnc_rotate", col, 4'b0010);

    // r=0,c=2 with a one-tick release glitch, then a full release
    k_rows = 4'b0001; k_col = 4'b0100; key_on = 1'b1;
    step(8);
    check("k2_detect_col",   col,                 4'b0100);
    check("k2_detect_valid", {3'b000, key_valid}, 4'h0);
    step(7);
    check("k2_pre_valid", {3'b000, key_valid}, 4'h0);
    step(1);
    check("k2_valid", {3'b000, key_valid}, 4'h1);
    check("k2_pulse", {3'b000, key_pulse}, 4'h1);
    check("k2_value", key_value,           4'h2);
    hold_check(4, 4'h2, "k2_held");
    key_on = 1'b0;
    hold_check(4, 4'h2, "k2_gap");
    key_on = 1'b1;
    hold_check(8, 4'h2, "k2_reclose");
    key_on = 1'b0;
    hold_check(11, 4'h2, "k2_release");
    check("k2_hold_col", col, 4'b0100);
    step(1);
    check("k2_fall_valid", {3'b000, key_valid}, 4'h0);
    check("k2_fall_col",   col,                 4'b1000);
    check("k2_fall_value", key_value,           4'h2);
    check("k2_fall_pulse", {3'b000, key_pulse}, 4'h0);

    // rows 1 and 2 together in column 0: never a valid sample
    k_rows = 4'b0110; k_col = 4'b0001; key_on = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(4);
      check("multi_col",   col,                 exp_cols[i]);
      check("multi_valid", {3'b000, key_valid}, 4'h0);
      check("multi_pulse", {3'b000, key_pulse}, 4'h0);
    end
    key_on = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
